// File: rtl/i2s_audio_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : i2s_audio_tx
//  Purpose  : Stereo sample FIFO feeding a Philips I2S transmitter that
//             generates its own BCLK/LRCK (64 BCLK per frame, MSB first,
//             one-BCLK data delay after each LRCK edge).
//  Revision : 1.0  initial release
// ============================================================================
module i2s_audio_tx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int BCLK_DIV   = 8
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           in_left,
    input  logic [DATA_W-1:0]           in_right,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        i2s_bclk,
    output logic                        i2s_lrck,
    output logic                        i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 underrun_cnt,
    input  logic                        clr_underrun
);

    localparam int                  c_addr_w   = $clog2(FIFO_DEPTH);
    localparam int                  c_div_w    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(BCLK_DIV - 1);
    localparam logic [c_addr_w:0]   c_full     = (c_addr_w + 1)'(FIFO_DEPTH);
    localparam logic [5:0]          c_l_first  = 6'd1;
    localparam logic [5:0]          c_l_last   = 6'(DATA_W);
    localparam logic [5:0]          c_r_first  = 6'd33;
    localparam logic [5:0]          c_r_last   = 6'(32 + DATA_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_level;
    logic                r_ready;

    // Serialiser state
    state_t              r_state;
    logic [c_div_w-1:0]  r_div_cnt;
    logic                r_bclk;
    logic [5:0]          r_bit_cnt;
    logic                r_lrck;
    logic                r_sdata;
    logic [DATA_W-1:0]   r_shift_l;
    logic [DATA_W-1:0]   r_shift_r;
    logic [15:0]         r_underrun;

    logic                w_push;
    logic                w_tick;
    logic                w_fall;
    logic                w_load;
    logic                w_pop;
    logic                w_underrun;
    logic [5:0]          w_next_bit;
    logic [c_addr_w:0]   w_level_nxt;
    logic [2*DATA_W-1:0] w_head;

    assign w_push     = in_valid & r_ready;
    assign w_tick     = enable & (r_div_cnt == c_div_last);
    assign w_fall     = w_tick & r_bclk;
    assign w_next_bit = r_bit_cnt + 6'd1;
    // A frame starts on the first enabled cycle after idle and on every 63->0 wrap
    assign w_load     = enable & ((r_state == ST_IDLE) | (w_fall & (r_bit_cnt == 6'd63)));
    assign w_pop      = w_load & (r_level != '0);
    assign w_underrun = w_load & (r_level == '0);
    assign w_head     = r_mem[r_rd_ptr];

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // FIFO data array, written on every accepted push
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_left, in_right};
        end
    end

    // FIFO pointers, level and registered ready
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != c_full);
        end
    end

    // BCLK divider, bit counter, LRCK and serial data; all change on BCLK fall
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else if (!enable) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
        end else begin
            r_state <= ST_RUN;
            if (w_tick) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_fall) begin
                r_bit_cnt <= w_next_bit;
                r_lrck    <= w_next_bit[5];
                if (w_next_bit >= c_l_first && w_next_bit <= c_l_last) begin
                    r_sdata   <= r_shift_l[DATA_W-1];
                    r_shift_l <= r_shift_l << 1;
                end else if (w_next_bit >= c_r_first && w_next_bit <= c_r_last) begin
                    r_sdata   <= r_shift_r[DATA_W-1];
                    r_shift_r <= r_shift_r << 1;
                end else begin
                    r_sdata <= 1'b0;
                end
            end
            // Load coincides only with bit 0, so it never collides with a shift
            if (w_load) begin
                r_shift_l <= w_pop ? w_head[2*DATA_W-1:DATA_W] : '0;
                r_shift_r <= w_pop ? w_head[DATA_W-1:0]        : '0;
            end
        end
    end

    // Saturating underrun counter; clear wins over a same-cycle increment
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_underrun <= '0;
        end else if (clr_underrun) begin
            r_underrun <= '0;
        end else if (w_underrun && (r_underrun != 16'hFFFF)) begin
            r_underrun <= r_underrun + 16'd1;
        end
    end

    assign in_ready     = r_ready;
    assign i2s_bclk     = r_bclk;
    assign i2s_lrck     = r_lrck;
    assign i2s_sdata    = r_sdata;
    assign fifo_level   = r_level;
    assign underrun_cnt = r_underrun;

endmodule
`default_nettype wire
